// File: rtl/arm_exec_pkg.sv
// arm_exec_pkg
//   Shared constants for the ARM execute stage: data-processing opcodes,
//   condition codes, NZCV flag bit positions and the execute FSM state type.
//   No ports (package).
package arm_exec_pkg;

  // Data-processing opcodes (ARM encoding)
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // NZCV bit positions
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exec_state_t;

endpackage

// File: rtl/arm_cond_check.sv
// arm_cond_check
//   Combinational ARM condition-field evaluation against NZCV.
//   Ports:
//     cond  [3:0] in  condition field
//     flags [3:0] in  NZCV, bit 3 = N
//     pass        out condition holds (NV never passes)
module arm_cond_check
  import arm_exec_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_execute_stage.sv
// arm_execute_stage
//   ARM data-processing execute stage. Performs the ALU op on Rn and the
//   shifted operand, evaluates the condition against the NZCV register it
//   owns, and presents a registered result over valid/ready.
//   Optional iterative multiplier enabled by macro ARM_MUL_EN; without it a
//   mul_op is a NOP (out_valid, wr_en=0, flags unchanged).
//
//   Ports:
//     clk, rst_n               clock / async active-low reset
//     in_valid, in_ready       issue handshake
//     alu_op, s_bit, cond      opcode, set-flags, condition field
//     mul_op                   multiply request
//     src1, src2_shifted, rd_in operands and destination
//     flush                    kill held result and same-cycle accept
//     out_valid, out_ready     writeback handshake
//     result, rd_out, wr_en    registered writeback payload
//     flags                    current NZCV (bit 3 = N)
//
//   state   | meaning
//   --------+------------------------------------------------------
//   ST_IDLE | accepting ops, single-cycle ALU path
//   ST_MUL  | iterative shift-add multiply, one multiplier bit/cycle
module arm_execute_stage
  import arm_exec_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic                  s_bit,
  input  logic [3:0]            cond,
  input  logic                  mul_op,
  input  logic [DATA_W-1:0]     src1,
  input  logic [DATA_W-1:0]     src2_shifted,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  wr_en,
  output logic [3:0]            flags
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  exec_state_t state;

  logic                  cond_pass;
  logic                  accept;
  logic                  mul_start;

  logic [DATA_W-1:0]     add_a, add_b;
  logic                  add_cin;
  logic                  is_arith;
  logic                  is_test;
  logic [DATA_W:0]       sum;
  logic [DATA_W-1:0]     alu_res;
  logic [3:0]            alu_flags;

  logic [DATA_W-1:0]     mul_acc, mul_mcand, mul_mplier, mul_acc_nxt;
  logic [CNT_W-1:0]      mul_cnt;
  logic                  mul_s;
  logic [REG_ADDR_W-1:0] mul_rd;

  arm_cond_check u_cond (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

`ifdef ARM_MUL_EN
  // A failing condition skips the multiply and goes straight to output.
  assign mul_start = cond_pass;
`else
  assign mul_start = 1'b0;
`endif

  assign is_test = (alu_op == OP_TST) || (alu_op == OP_TEQ) ||
                   (alu_op == OP_CMP) || (alu_op == OP_CMN);

  // Every arithmetic op is a + b + cin; subtraction inverts one side so that
  // carry out is NOT borrow.
  always_comb begin
    add_a    = src1;
    add_b    = src2_shifted;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (alu_op)
      OP_SUB, OP_CMP: begin add_b = ~src2_shifted; add_cin = 1'b1; end
      OP_RSB: begin add_a = src2_shifted; add_b = ~src1; add_cin = 1'b1; end
      OP_ADD, OP_CMN: add_cin = 1'b0;
      OP_ADC: add_cin = flags[FLAG_C];
      OP_SBC: begin add_b = ~src2_shifted; add_cin = flags[FLAG_C]; end
      OP_RSC: begin add_a = src2_shifted; add_b = ~src1; add_cin = flags[FLAG_C]; end
      default: is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

  always_comb begin
    alu_res = sum[DATA_W-1:0];
    case (alu_op)
      OP_AND, OP_TST: alu_res = src1 & src2_shifted;
      OP_EOR, OP_TEQ: alu_res = src1 ^ src2_shifted;
      OP_ORR:         alu_res = src1 | src2_shifted;
      OP_MOV:         alu_res = src2_shifted;
      OP_BIC:         alu_res = src1 & ~src2_shifted;
      OP_MVN:         alu_res = ~src2_shifted;
      default:        alu_res = sum[DATA_W-1:0];
    endcase
  end

  always_comb begin
    alu_flags         = flags;
    alu_flags[FLAG_N] = alu_res[DATA_W-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    if (is_arith) begin
      alu_flags[FLAG_C] = sum[DATA_W];
      alu_flags[FLAG_V] = (add_a[DATA_W-1] == add_b[DATA_W-1]) &&
                          (sum[DATA_W-1] != add_a[DATA_W-1]);
    end
  end

  assign mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      rd_out     <= '0;
      wr_en      <= 1'b0;
      flags      <= 4'b0000;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      mul_s      <= 1'b0;
      mul_rd     <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (mul_op && mul_start) begin
              state      <= ST_MUL;
              out_valid  <= 1'b0;
              mul_acc    <= '0;
              mul_mcand  <= src1;
              mul_mplier <= src2_shifted;
              mul_cnt    <= CNT_LAST;
              mul_s      <= s_bit;
              mul_rd     <= rd_in;
            end else if (mul_op) begin
              out_valid <= 1'b1;
              result    <= '0;
              rd_out    <= rd_in;
              wr_en     <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_res;
              rd_out    <= rd_in;
              wr_en     <= cond_pass && !is_test;
              if (cond_pass && (is_test || s_bit))
                flags <= alu_flags;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          mul_acc    <= mul_acc_nxt;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt - CNT_ONE;
          if (mul_cnt == '0) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            result    <= mul_acc_nxt;
            rd_out    <= mul_rd;
            wr_en     <= 1'b1;
            if (mul_s) begin
              flags[FLAG_N] <= mul_acc_nxt[DATA_W-1];
              flags[FLAG_Z] <= (mul_acc_nxt == '0);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_execute_stage.sv
// tb_arm_execute_stage
//   Directed scenarios with literal expectations, then randomized traffic,
//   all compared every cycle against a behavioural model of the stage.
//   Honors ARM_MUL_EN the same way as the design.
module tb_arm_execute_stage;
  import arm_exec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic        s_bit;
  logic [3:0]  cond;
  logic        mul_op;
  logic [31:0] src1;
  logic [31:0] src2_shifted;
  logic [3:0]  rd_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  rd_out;
  logic        wr_en;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  arm_execute_stage #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .s_bit        (s_bit),
    .cond         (cond),
    .mul_op       (mul_op),
    .src1         (src1),
    .src2_shifted (src2_shifted),
    .rd_in        (rd_in),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .rd_out       (rd_out),
    .wr_en        (wr_en),
    .flags        (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !(cy && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return !(!z && (n == v));
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Arithmetic done in 64-bit integers: carry = unsigned result out of range
  // (or no borrow), overflow = signed result out of 32-bit range.
  function automatic void model_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] f,
                                    output logic [31:0] r, output logic [3:0] nf,
                                    output bit test_op);
    longint ua, ub, sa, sb, ur, sr, cin;
    bit arith, subtr;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cin = longint'(f[1]);
    arith = 1; subtr = 0; ur = 0; sr = 0; r = '0;
    nf = f;
    test_op = (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    case (op)
      OP_ADD, OP_CMN: begin ur = ua + ub; sr = sa + sb; end
      OP_ADC: begin ur = ua + ub + cin; sr = sa + sb + cin; end
      OP_SUB, OP_CMP: begin ur = ua - ub; sr = sa - sb; subtr = 1; end
      OP_SBC: begin ur = ua - ub - (1 - cin); sr = sa - sb - (1 - cin); subtr = 1; end
      OP_RSB: begin ur = ub - ua; sr = sb - sa; subtr = 1; end
      OP_RSC: begin ur = ub - ua - (1 - cin); sr = sb - sa - (1 - cin); subtr = 1; end
      OP_AND, OP_TST: begin r = a & b; arith = 0; end
      OP_EOR, OP_TEQ: begin r = a ^ b; arith = 0; end
      OP_ORR: begin r = a | b; arith = 0; end
      OP_MOV: begin r = b; arith = 0; end
      OP_BIC: begin r = a & ~b; arith = 0; end
      default: begin r = ~b; arith = 0; end
    endcase
    if (arith) begin
      r = ur[31:0];
      nf[1] = subtr ? (ur >= 0) : (ur > longint'(32'hFFFF_FFFF));
      nf[0] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end
    nf[3] = r[31];
    nf[2] = (r == 32'h0);
  endfunction

  bit          m_valid, m_wr, p_s;
  logic [31:0] m_result, p_prod, mr;
  logic [3:0]  m_rd, m_flags, p_rd, mnf;
  int          m_busy;
  bit          m_ir, m_acc, m_pass, m_test;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_wr = 0; m_result = '0; m_rd = '0; m_flags = '0; m_busy = 0;
    end else begin
      m_ir  = (m_busy == 0) && (!m_valid || out_ready);
      m_acc = in_valid && m_ir && !flush;
      if (flush) begin
        m_valid = 0; m_busy = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1; m_wr = 1; m_result = p_prod; m_rd = p_rd;
          if (p_s) begin m_flags[3] = p_prod[31]; m_flags[2] = (p_prod == 32'h0); end
        end
      end else if (m_acc) begin
        m_pass = cond_ok(cond, m_flags);
        if (mul_op) begin
`ifdef ARM_MUL_EN
          if (m_pass) begin
            m_busy = 32; m_valid = 0;
            p_prod = src1 * src2_shifted; p_s = s_bit; p_rd = rd_in;
          end else begin
            m_valid = 1; m_wr = 0; m_rd = rd_in;
          end
`else
          m_valid = 1; m_wr = 0; m_rd = rd_in;
`endif
        end else begin
          model_alu(alu_op, src1, src2_shifted, m_flags, mr, mnf, m_test);
          m_valid = 1; m_rd = rd_in; m_result = mr;
          m_wr = m_pass && !m_test;
          if (m_pass && (m_test || s_bit)) m_flags = mnf;
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("in_ready", in_ready, (m_busy == 0) && (!m_valid || out_ready));
      check("out_valid", out_valid, m_valid);
      check("flags", flags, m_flags);
      if (m_valid) begin
        check("wr_en", wr_en, m_wr);
        check("rd_out", rd_out, m_rd);
        if (m_wr) check("result", result, m_result);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic s, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] rd, input logic mul = 1'b0);
    in_valid = 1'b1; alu_op = op; s_bit = s; cond = c;
    src1 = a; src2_shifted = b; rd_in = rd; mul_op = mul;
  endtask

  task automatic idle();
    in_valid = 1'b0; mul_op = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int lowcnt;

  initial begin
    rst_n = 0; in_valid = 0; alu_op = '0; s_bit = 0; cond = COND_AL; mul_op = 0;
    src1 = '0; src2_shifted = '0; rd_in = '0; flush = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    check("rst out_valid", out_valid, 1'b0);
    check("rst result", result, 32'h0);
    check("rst wr_en", wr_en, 1'b0);
    check("rst flags", flags, 4'b0000);
    #1 rst_n = 1;
    chk_en = 1;

    // ADDS overflow into sign bit
    step(); set_op(OP_ADD, 1, COND_AL, 32'h7FFF_FFFF, 32'h1, 4'd3);
    step(); idle();
    @(negedge clk);
    check("adds result", result, 32'h8000_0000);
    check("adds wr_en", wr_en, 1'b1);
    check("adds flags", flags, 4'b1001);

    // CMP then ADDEQ next cycle, then ADDNE
    step(); set_op(OP_CMP, 0, COND_AL, 32'd5, 32'd5, 4'd0);
    step(); set_op(OP_ADD, 0, COND_EQ, 32'd1, 32'd1, 4'd4);
    @(negedge clk);
    check("cmp flags", flags, 4'b0110);
    check("cmp wr_en", wr_en, 1'b0);
    step(); set_op(OP_ADD, 0, COND_NE, 32'd1, 32'd1, 4'd5);
    @(negedge clk);
    check("addeq result", result, 32'd2);
    check("addeq wr_en", wr_en, 1'b1);
    check("addeq flags", flags, 4'b0110);
    step(); idle();
    @(negedge clk);
    check("addne valid", out_valid, 1'b1);
    check("addne wr_en", wr_en, 1'b0);

    // SUBS borrow, then ADC using C=0
    step(); set_op(OP_SUB, 1, COND_AL, 32'd0, 32'd1, 4'd6);
    step(); set_op(OP_ADC, 0, COND_AL, 32'd0, 32'd0, 4'd7);
    @(negedge clk);
    check("subs result", result, 32'hFFFF_FFFF);
    check("subs flags", flags, 4'b1000);
    step(); idle();
    @(negedge clk);
    check("adc result", result, 32'h0);
    check("adc wr_en", wr_en, 1'b1);

    // Backpressure: hold 3 cycles, then 1/cycle
    step(); out_ready = 0; set_op(OP_MOV, 0, COND_AL, 32'h0, 32'd11, 4'd1);
    step(); set_op(OP_MOV, 0, COND_AL, 32'h0, 32'd22, 4'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold result", result, 32'd11);
      check("hold in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1;
    step(); set_op(OP_MOV, 0, COND_AL, 32'h0, 32'd33, 4'd3);
    @(negedge clk);
    check("b2b first", result, 32'd22);
    step(); idle();
    @(negedge clk);
    check("b2b second", result, 32'd33);
    check("b2b rd", rd_out, 4'd3);

    // flush with same-cycle SUBS
    step(); flush = 1; set_op(OP_SUB, 1, COND_AL, 32'd5, 32'd9, 4'd8);
    step(); flush = 0; idle();
    @(negedge clk);
    check("flush valid", out_valid, 1'b0);
    check("flush flags", flags, 4'b1000);

    // Multiply: CMP sets C=1 V=1 first
    step(); set_op(OP_CMP, 0, COND_AL, 32'h8000_0000, 32'h1, 4'd0);
    step(); set_op(OP_MOV, 1, COND_AL, 32'h1_0000, 32'h1_0000, 4'd9, 1'b1);
    @(negedge clk);
    check("cmp cv flags", flags, 4'b0011);
    step(); idle();
`ifdef ARM_MUL_EN
    lowcnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
      lowcnt++;
    end
    check("mul busy cycles", lowcnt, 32);
    check("mul valid", out_valid, 1'b1);
    check("mul result", result, 32'h0);
    check("mul wr_en", wr_en, 1'b1);
    check("mul flags", flags, 4'b0111);
`else
    lowcnt = 0;
    @(negedge clk);
    check("mulnop valid", out_valid, 1'b1);
    check("mulnop wr_en", wr_en, 1'b0);
    check("mulnop flags", flags, 4'b0011);
    check("mulnop in_ready", in_ready, 1'b1);
`endif

    // Reset mid-stream
    step(); set_op(OP_ADD, 1, COND_AL, 32'd1, 32'd2, 4'd10);
    step(); idle();
    #2 rst_n = 0;
    #1;
    check("midrst valid", out_valid, 1'b0);
    check("midrst result", result, 32'h0);
    check("midrst rd", rd_out, 4'h0);
    check("midrst wr_en", wr_en, 1'b0);
    check("midrst flags", flags, 4'b0000);
    @(negedge clk); #1 rst_n = 1;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      in_valid     = ($urandom_range(0, 3) != 0);
      alu_op       = 4'($urandom_range(0, 15));
      s_bit        = 1'($urandom_range(0, 1));
      cond         = ($urandom_range(0, 1) != 0) ? COND_AL : 4'($urandom_range(0, 15));
      mul_op       = ($urandom_range(0, 19) == 0);
      src1         = pick();
      src2_shifted = pick();
      rd_in        = 4'($urandom_range(0, 15));
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 29) == 0);
    end
    step(); idle(); flush = 0; out_ready = 1;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
